// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for a ROWS x COLS systolic array: accepts K operand beats
// through a ready/valid handshake, skews them into the array, drains the
// array, snapshots the accumulators and streams the result out row by row.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   start, cfg_k, cfg_acc      tile start, reduction depth, accumulate mode
//   in_valid/in_ready          operand beat handshake
//   in_a, in_w                 activations (per row), weights (per column)
//   arr_fire, arr_clr          array advance enable, accumulator clear
//   arr_a, arr_w               skewed operands to the array edges
//   arr_acc                    array accumulators, PE(r,c) at (r*COLS+c)
//   out_valid/out_ready        result row handshake
//   out_data, out_row          result row and its index
//   busy, done                 tile in progress, tile finished pulse
module sa_tile_sequencer #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 32,
    parameter int KW       = 16,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [KW-1:0]                cfg_k,
    input  logic                         cfg_acc,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS*INWIDTH-1:0]      in_a,
    input  logic [COLS*INWIDTH-1:0]      in_w,
    output logic                         arr_fire,
    output logic                         arr_clr,
    output logic [ROWS*INWIDTH-1:0]      arr_a,
    output logic [COLS*INWIDTH-1:0]      arr_w,
    input  logic [ROWS*COLS*OUTWIDTH-1:0] arr_acc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLS*OUTWIDTH-1:0]     out_data,
    output logic [RW-1:0]                out_row,
    output logic                         busy,
    output logic                         done
);

    localparam int DN = ROWS + COLS - 1;
    localparam int DW = $clog2(DN + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, UNLOAD} state_t;

    state_t                        state, state_nx;
    logic [KW-1:0]                 k_q, beats_q;
    logic [DW-1:0]                 drain_q;
    logic [RW-1:0]                 row_q;
    logic                          done_q;
    logic [ROWS*COLS*OUTWIDTH-1:0] snap;
    logic                          feed_beat, drain_end, last_row;
    logic [ROWS*INWIDTH-1:0]       a_in;
    logic [COLS*INWIDTH-1:0]       w_in;

    assign feed_beat = (state == FEED) && in_valid;
    // One extra DRAIN cycle without fire lets the last products settle
    // into the accumulators before the snapshot.
    assign drain_end = (drain_q == DW'(DN));
    assign last_row  = (row_q == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        arr_fire  = 1'b0;
        arr_clr   = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && cfg_k != '0) begin
                    state_nx = FEED;
                    arr_clr  = !cfg_acc;
                end
            end
            FEED: begin
                in_ready = 1'b1;
                arr_fire = in_valid;
                if (in_valid && beats_q == k_q - KW'(1)) state_nx = DRAIN;
            end
            DRAIN: begin
                arr_fire = !drain_end;
                if (drain_end) state_nx = UNLOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && last_row) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            k_q     <= '0;
            beats_q <= '0;
            drain_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            snap    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    beats_q <= '0;
                    drain_q <= '0;
                    row_q   <= '0;
                    if (start) begin
                        k_q    <= cfg_k;
                        done_q <= (cfg_k == '0);
                    end
                end
                FEED: if (in_valid) beats_q <= beats_q + KW'(1);
                DRAIN: begin
                    drain_q <= drain_q + DW'(1);
                    if (drain_end) snap <= arr_acc;
                end
                UNLOAD: begin
                    if (out_ready) begin
                        row_q  <= last_row ? '0 : row_q + RW'(1);
                        done_q <= last_row;
                    end
                end
                default: ;
            endcase
        end
    end

    // Zeros enter the skew chains outside accepted beats, so DRAIN
    // flushes the chains with zero operands.
    assign a_in = feed_beat ? in_a : '0;
    assign w_in = feed_beat ? in_w : '0;

    assign arr_a[INWIDTH-1:0] = a_in[INWIDTH-1:0];
    assign arr_w[INWIDTH-1:0] = w_in[INWIDTH-1:0];

    for (genvar r = 1; r < ROWS; r++) begin : g_skew_a
        localparam int SW = r * INWIDTH;
        logic [SW-1:0] sr;
        always_ff @(posedge clk) begin
            if (!rstn)         sr <= '0;
            else if (arr_fire) sr <= SW'({sr, a_in[r*INWIDTH +: INWIDTH]});
        end
        assign arr_a[r*INWIDTH +: INWIDTH] = sr[SW-1 -: INWIDTH];
    end

    for (genvar c = 1; c < COLS; c++) begin : g_skew_w
        localparam int SW = c * INWIDTH;
        logic [SW-1:0] sr;
        always_ff @(posedge clk) begin
            if (!rstn)         sr <= '0;
            else if (arr_fire) sr <= SW'({sr, w_in[c*INWIDTH +: INWIDTH]});
        end
        assign arr_w[c*INWIDTH +: INWIDTH] = sr[SW-1 -: INWIDTH];
    end

    assign out_data = snap[int'(row_q)*COLS*OUTWIDTH +: COLS*OUTWIDTH];
    assign out_row  = row_q;
    assign busy     = (state != IDLE);
    assign done     = done_q;

endmodule
